run_ctrl: RTL and testbench

RUN_CTRL -- requirements
Module: run_ctrl

---
 rtl/run_ctrl_pkg.sv | 14 +
 rtl/run_ctrl_edge_det.sv | 21 ++
 rtl/run_ctrl.sv | 86 ++++++++
 tb/tb_run_ctrl.sv | 199 +++++++++++++++++++
 4 files changed

// File: rtl/run_ctrl_pkg.sv
// Shared types and default sizing for the run controller.
package run_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ARMED = 2'd1,
        ST_RUN   = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    localparam int          DEF_CNT_W      = 16;
    localparam int unsigned DEF_MAX_CYCLES = 32'h0000_FFF0;

endpackage

// File: rtl/run_ctrl_edge_det.sv
// Registers one input and flags its rising and falling edges against that registered copy.
module edge_det (
    input  logic clk,
    input  logic reset,
    input  logic sig,
    output logic rise,
    output logic fall
);

    logic sig_q;

    // NOTE: sequential state is always assigned with <= so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (!reset) sig_q <= 1'b0;
        else        sig_q <= sig;
    end

    assign rise = sig & ~sig_q;
    assign fall = ~sig & sig_q;

endmodule

// File: rtl/run_ctrl.sv
// Run controller: arms on a Start pulse, runs the core until Halt, then holds Ack.
// Optional watchdog (TimedOut port, MAX_CYCLES limit) is built only with RUN_CTRL_TIMEOUT_EN.
module run_ctrl
    import run_ctrl_pkg::*;
#(
    parameter int          CNT_W      = DEF_CNT_W,
    parameter int unsigned MAX_CYCLES = DEF_MAX_CYCLES
) (
    input  logic             Clk,
    input  logic             Reset,
    input  logic             Start,
    input  logic             Halt,
    output logic             Ack,
    output logic             Run,
    output logic             PcInit,
    output logic [CNT_W-1:0] CycleCount
`ifdef RUN_CTRL_TIMEOUT_EN
    ,
    output logic             TimedOut
`endif
);

    state_t           state;
    state_t           state_next;
    logic             start_rise;
    logic             start_fall;
    logic             arm;
    logic             timeout_hit;
    logic [CNT_W-1:0] count_inc;

    edge_det u_start_edge (
        .clk   (Clk),
        .reset (Reset),
        .sig   (Start),
        .rise  (start_rise),
        .fall  (start_fall)
    );

    assign arm       = ((state == ST_IDLE) || (state == ST_DONE)) && start_rise;
    assign count_inc = (&CycleCount) ? CycleCount : CycleCount + 1'b1;

`ifdef RUN_CTRL_TIMEOUT_EN
    // Halt in the same cycle takes priority, so a program ending exactly at the limit is not a timeout.
    assign timeout_hit = (state == ST_RUN) && !Halt && (64'(count_inc) >= 64'(MAX_CYCLES));

    always_ff @(posedge Clk) begin
        if (!Reset)           TimedOut <= 1'b0;
        else if (arm)         TimedOut <= 1'b0;
        else if (timeout_hit) TimedOut <= 1'b1;
    end
`else
    logic unused_max_cycles;
    assign unused_max_cycles = ^MAX_CYCLES;
    assign timeout_hit       = 1'b0;
`endif

    always_ff @(posedge Clk) begin
        if (!Reset) state <= ST_IDLE;
        else        state <= state_next;
    end

    // NOTE: default assignment first so no path through the case leaves state_next unassigned (no latch).
    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE,
            ST_DONE:  if (start_rise)           state_next = ST_ARMED;
            ST_ARMED: if (start_fall)           state_next = ST_RUN;
            ST_RUN:   if (Halt || timeout_hit) state_next = ST_DONE;
            default:                            state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge Clk) begin
        if (!Reset)               CycleCount <= '0;
        else if (arm)             CycleCount <= '0;
        else if (state == ST_RUN) CycleCount <= count_inc;
    end

    always_comb begin
        Run    = (state == ST_RUN);
        PcInit = (state == ST_IDLE) || (state == ST_ARMED);
        Ack    = (state == ST_DONE);
    end

endmodule

// File: tb/tb_run_ctrl.sv
// Self-checking bench for run_ctrl: directed scenarios plus randomized programs against a phase-level model.
module tb_run_ctrl;

    logic        Clk   = 1'b0;
    logic        Reset = 1'b0;
    logic        Start = 1'b0;
    logic        Halt  = 1'b0;
    logic        ack;
    logic        run;
    logic        pc_init;
    logic [15:0] cycle_count;
    logic [3:0]  small_count;
    logic        unused_small_ack;
    logic        unused_small_run;
    logic        unused_small_pc;
`ifdef RUN_CTRL_TIMEOUT_EN
    logic        timed_out;
    logic        unused_small_to;
`endif

    int n_checks = 0;
    int n_fail   = 0;

    run_ctrl #(.CNT_W(16), .MAX_CYCLES(20)) dut (
        .Clk        (Clk),
        .Reset      (Reset),
        .Start      (Start),
        .Halt       (Halt),
        .Ack        (ack),
        .Run        (run),
        .PcInit     (pc_init),
        .CycleCount (cycle_count)
`ifdef RUN_CTRL_TIMEOUT_EN
        ,
        .TimedOut   (timed_out)
`endif
    );

    // Narrow counter instance shares stimulus and exposes saturation quickly.
    run_ctrl #(.CNT_W(4), .MAX_CYCLES(20)) dut_small (
        .Clk        (Clk),
        .Reset      (Reset),
        .Start      (Start),
        .Halt       (Halt),
        .Ack        (unused_small_ack),
        .Run        (unused_small_run),
        .PcInit     (unused_small_pc),
        .CycleCount (small_count)
`ifdef RUN_CTRL_TIMEOUT_EN
        ,
        .TimedOut   (unused_small_to)
`endif
    );

    always #5 Clk = ~Clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge Clk);
        #1;
    endtask

    function automatic int sat15(input int v);
        return (v > 15) ? 15 : v;
    endfunction

    function automatic logic rnd_bit();
        return 1'($urandom_range(0, 1));
    endfunction

    task automatic expect_outs(input string tag, input bit r, input bit p, input bit a,
                               input int cnt, input int scnt, input bit to, input bit chk_pc);
        check({tag, ".run"}, 32'(run), 32'(r));
        if (chk_pc) check({tag, ".pcinit"}, 32'(pc_init), 32'(p));
        check({tag, ".ack"}, 32'(ack), 32'(a));
        check({tag, ".count"}, 32'(cycle_count), cnt);
        check({tag, ".small_count"}, 32'(small_count), scnt);
`ifdef RUN_CTRL_TIMEOUT_EN
        check({tag, ".timed_out"}, 32'(timed_out), 32'(to));
`else
        if (to) check({tag, ".timed_out_unexpected"}, 32'(to), 32'd0);
`endif
    endtask

    // One program: Start held for 'hold' cycles, then 'n' Run cycles ending with Halt on the last one.
    task automatic run_program(input string tag, input int hold, input int n, input bit noise);
        Start = 1'b1;
        Halt  = noise ? rnd_bit() : 1'b0;
        step();
        expect_outs({tag, ".arm"}, 0, 1, 0, 0, 0, 0, 1);
        for (int i = 1; i < hold; i++) begin
            Halt = noise ? rnd_bit() : 1'b0;
            step();
            expect_outs({tag, ".arm_hold"}, 0, 1, 0, 0, 0, 0, 1);
        end
        Start = 1'b0;
        Halt  = noise ? rnd_bit() : 1'b0;
        step();
        for (int k = 1; k <= n; k++) begin
            expect_outs($sformatf("%s.run%0d", tag, k), 1, 0, 0, k - 1, sat15(k - 1), 0, 1);
            Halt  = (k == n);
            Start = (noise && k < n) ? rnd_bit() : 1'b0;
            step();
        end
        Halt  = 1'b0;
        Start = 1'b0;
        expect_outs({tag, ".done"}, 0, 0, 1, n, sat15(n), 0, 0);
        repeat ($urandom_range(1, 3)) begin
            Halt = noise ? rnd_bit() : 1'b0;
            step();
            expect_outs({tag, ".done_hold"}, 0, 0, 1, n, sat15(n), 0, 0);
        end
        Halt = 1'b0;
    endtask

    initial begin
        Reset = 1'b0;
        Start = 1'b0;
        Halt  = 1'b0;
        step();
        step();
        expect_outs("reset", 0, 1, 0, 0, 0, 0, 1);
        Reset = 1'b1;
        step();
        expect_outs("idle", 0, 1, 0, 0, 0, 0, 1);

        // Halt while idle must not start or acknowledge anything.
        Halt = 1'b1;
        step();
        expect_outs("idle_halt", 0, 1, 0, 0, 0, 0, 1);
        Halt = 1'b0;
        step();
        expect_outs("idle_after_halt", 0, 1, 0, 0, 0, 0, 1);

        run_program("dir10", 1, 10, 1'b0);
        run_program("again", 2, 3, 1'b0);

        // Reset asserted during Run cycle 5 aborts straight to idle without an Ack.
        Start = 1'b1;
        step();
        Start = 1'b0;
        step();
        for (int k = 1; k <= 5; k++) begin
            expect_outs($sformatf("abort.run%0d", k), 1, 0, 0, k - 1, k - 1, 0, 1);
            if (k < 5) step();
        end
        Reset = 1'b0;
        step();
        expect_outs("abort.reset", 0, 1, 0, 0, 0, 0, 1);
        Reset = 1'b1;
        repeat (3) begin
            step();
            expect_outs("abort.idle", 0, 1, 0, 0, 0, 0, 1);
        end

        for (int i = 0; i < 20; i++)
            run_program($sformatf("rnd%0d", i), int'($urandom_range(1, 4)), int'($urandom_range(1, 20)), 1'b1);

        // Long program with no Halt: watchdog at 20 cycles when built in, otherwise Run persists.
        Start = 1'b1;
        step();
        Start = 1'b0;
        step();
        for (int k = 1; k <= 26; k++) begin
`ifdef RUN_CTRL_TIMEOUT_EN
            if (k <= 20) expect_outs($sformatf("wd.run%0d", k), 1, 0, 0, k - 1, sat15(k - 1), 0, 1);
            else begin
                check($sformatf("wd.run%0d.run", k), 32'(run), 32'd0);
                check($sformatf("wd.run%0d.ack", k), 32'(ack), 32'd1);
                check($sformatf("wd.run%0d.timed_out", k), 32'(timed_out), 32'd1);
                check($sformatf("wd.run%0d.count", k), 32'(cycle_count), 32'd20);
                check($sformatf("wd.run%0d.small_count", k), 32'(small_count), sat15(k - 1));
            end
`else
            expect_outs($sformatf("wd.run%0d", k), 1, 0, 0, k - 1, sat15(k - 1), 0, 1);
`endif
            Halt = (k == 26);
            step();
        end
        Halt = 1'b0;
`ifdef RUN_CTRL_TIMEOUT_EN
        expect_outs("wd.done", 0, 0, 1, 20, 15, 1, 0);
`else
        expect_outs("wd.done", 0, 0, 1, 26, 15, 0, 0);
`endif
        run_program("after_wd", 1, 4, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
